// File: rtl/ppu_pkg.sv
// Shared types for the PPU command writer: command record, table codes and
// the address-forming helper used by the bus side.
package ppu_pkg;

  typedef enum logic [1:0] {
    ATTR   = 2'd0,
    SPRITE = 2'd1,
    COLOR  = 2'd2
  } ppu_table_t;

  localparam int VACTIVE_L = 480;
  localparam int VTOTAL_L  = 525;
  localparam int TABLE_LSB = 10;

  // tbl is kept as raw bits so the illegal code 3 can be carried to the pop side
  typedef struct packed {
    logic [1:0]  tbl;
    logic [7:0]  index;
    logic [31:0] data;
  } ppu_cmd_t;

  function automatic logic [11:0] ppu_addr(input ppu_cmd_t c);
    return (12'(c.tbl) << TABLE_LSB) | 12'(c.index);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// First-word-fall-through FIFO of ppu_cmd_t; pointers carry one extra wrap
// bit so occupancy is a plain subtraction.
module cmd_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  ppu_cmd_t                 din,
  output ppu_cmd_t                 dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  ppu_cmd_t    mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign count = wr_ptr - rd_ptr;
  assign full  = count[AW];
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ppu_cmd_writer.sv
// Buffers table-update commands and replays them as HOLD-cycle PPU write beats.
// PPU_CMD_VBLANK_GATE_EN restricts beat starts to the vertical blanking window.
module ppu_cmd_writer
  import ppu_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int HOLD    = 2,
  parameter int VACTIVE = VACTIVE_L,
  parameter int VTOTAL  = VTOTAL_L
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_table,
  input  logic [7:0]             cmd_index,
  input  logic [31:0]            cmd_data,
  input  logic [9:0]             vcount,
  output logic                   chipselect,
  output logic                   write,
  output logic [11:0]            address,
  output logic [31:0]            writedata,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_illegal
);

  localparam int HW = $clog2(HOLD);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BEAT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [9:0] V_LO   = 10'(VACTIVE);
  localparam logic [9:0] V_HI   = 10'(VTOTAL - 2);

  logic [1:0]    state;
  logic [HW-1:0] hold_cnt;
  ppu_cmd_t      cmd_in;
  ppu_cmd_t      head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          vblank;
  logic          push;
  logic          can_start;

`ifdef PPU_CMD_VBLANK_GATE_EN
  assign vblank = (vcount >= V_LO) && (vcount <= V_HI);
`else
  logic unused_vcount;
  assign unused_vcount = ^{vcount, V_LO, V_HI};
  assign vblank        = 1'b1;
`endif

  assign cmd_in    = '{tbl: cmd_table, index: cmd_index, data: cmd_data};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign can_start = ((state == S_IDLE) || (state == S_GAP)) && !fifo_empty && vblank;
  assign busy      = (state != S_IDLE);

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (can_start),
    .din     (cmd_in),
    .dout    (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      chipselect  <= 1'b0;
      write       <= 1'b0;
      address     <= '0;
      writedata   <= '0;
      frame_done  <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (push && (cmd_table == 2'd3)) err_illegal <= 1'b1;
      case (state)
        S_BEAT: begin
          // The PPU needs the address settled a cycle before it sees write.
          if (hold_cnt == '0) begin
            state      <= S_GAP;
            chipselect <= 1'b0;
            write      <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          // An illegal head is popped here and dropped without a bus cycle.
          if (can_start && (head.tbl != 2'd3)) begin
            state      <= S_BEAT;
            hold_cnt   <= HW'(HOLD - 1);
            chipselect <= 1'b1;
            write      <= 1'b1;
            address    <= ppu_addr(head);
            writedata  <= head.data;
          end else begin
            state <= S_IDLE;
            if ((state == S_GAP) && fifo_empty && vblank) frame_done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_cmd_writer.sv
// Scoreboard bench for ppu_cmd_writer: drivers queue expected beats, a negedge
// monitor checks every beat it sees. Expectations follow PPU_CMD_VBLANK_GATE_EN.
module tb_ppu_cmd_writer;
  import ppu_pkg::*;

  localparam int DEPTH = 16;
  localparam int HOLD  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_table = 2'd0;
  logic [7:0]  cmd_index = 8'd0;
  logic [31:0] cmd_data = 32'd0;
  logic [9:0]  vcount = 10'd0;
  logic        chipselect;
  logic        write;
  logic [11:0] address;
  logic [31:0] writedata;
  logic [4:0]  fifo_count;
  logic        busy;
  logic        frame_done;
  logic        err_illegal;

  ppu_cmd_writer #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_table(cmd_table), .cmd_index(cmd_index), .cmd_data(cmd_data),
    .vcount(vcount), .chipselect(chipselect), .write(write), .address(address),
    .writedata(writedata), .fifo_count(fifo_count), .busy(busy),
    .frame_done(frame_done), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [43:0] exp_q[$];   // {address, writedata} of each expected beat
  int rise_q[$];
  int cyc = 0;
  int beats = 0;
  int frames = 0;
  int last_rise = -1000;
  int run_len = 0;
  bit in_beat = 1'b0;
  bit prev_fd = 1'b0;
  logic [43:0] cur = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired, got timeout, expected completion (t=%0t)", name, $time);
  endtask

  // Monitor: one beat = chipselect high for HOLD cycles with stable bus.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      in_beat   = 1'b0;
      run_len   = 0;
      prev_fd   = 1'b0;
      last_rise = -1000;
    end else begin
      if (chipselect === 1'b1) begin
        if (!in_beat) begin
          in_beat = 1'b1;
          run_len = 0;
          beats++;
          rise_q.push_back(cyc);
          check("beat_spacing_ok", 64'(cyc - last_rise >= HOLD + 1), 64'd1);
          last_rise = cyc;
          if (exp_q.size() == 0) check("beat_pending_count", 64'(exp_q.size()), 64'd1);
          else cur = exp_q.pop_front();
        end
        run_len++;
        check("beat_write", 64'(write), 64'd1);
        check("beat_addr", 64'(address), 64'(cur[43:32]));
        check("beat_data", 64'(writedata), 64'(cur[31:0]));
      end else if (in_beat) begin
        in_beat = 1'b0;
        check("beat_len", 64'(run_len), 64'(HOLD));
        check("gap_write", 64'(write), 64'd0);
        check("gap_addr_hold", 64'(address), 64'(cur[43:32]));
      end
      if (frame_done === 1'b1) begin
        frames++;
        check("frame_done_single", 64'(prev_fd), 64'd0);
      end
      prev_fd = (frame_done === 1'b1);
    end
  end

  task automatic push(input logic [1:0] t, input logic [7:0] i, input logic [31:0] d);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check("push_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_table = t;
    cmd_index = i;
    cmd_data  = d;
    if (t != 2'd3) exp_q.push_back({t, 2'b00, i, d});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(fifo_count == 0 && busy == 1'b0 && chipselect == 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) bound_fail(name);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cs(input string name, input int budget);
    int n = 0;
    while (chipselect !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) bound_fail(name);
  endtask

  initial begin
    int b0, f0, r0, acc, stall, budget, n_offer;
    bit rdy;

    // Reset
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_cs", 64'(chipselect), 64'd0);
    check("rst_write", 64'(write), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_err", 64'(err_illegal), 64'd0);
    check("rst_addr", 64'(address), 64'd0);
    check("rst_wdata", 64'(writedata), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd1);

    // Single ATTR command pushed in active video
    b0 = beats; f0 = frames;
    @(posedge clk); #1;
    vcount = 10'd100;
    push(ATTR, 8'd3, 32'hA5A5_0010);
    @(negedge clk);
    check("t1_count_after_push", 64'(fifo_count), 64'd1);
    check("t1_busy_after_push", 64'(busy), 64'd0);
    check("t1_cs_after_push", 64'(chipselect), 64'd0);
`ifdef PPU_CMD_VBLANK_GATE_EN
    repeat (5) @(negedge clk);
    check("t1_no_beat_active", 64'(beats - b0), 64'd0);
    check("t1_count_held", 64'(fifo_count), 64'd1);
    check("t1_busy_held", 64'(busy), 64'd0);
    vcount = 10'd480;
`else
    @(negedge clk);
    check("t1_latency_cs", 64'(chipselect), 64'd1);
    check("t1_latency_write", 64'(write), 64'd1);
    check("t1_popped", 64'(fifo_count), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
`endif
    wait_idle("t1_idle", 100);
    check("t1_beats", 64'(beats - b0), 64'd1);
    check("t1_frames", 64'(frames - f0), 64'd1);
    check("t1_count_end", 64'(fifo_count), 64'd0);

    // 16 back-to-back commands inside blanking
    b0 = beats; f0 = frames; r0 = rise_q.size();
    vcount = 10'd490;
    for (int k = 0; k < 16; k++) begin
      check("t2_ready", 64'(cmd_ready), 64'd1);
      push(2'(k % 3), (k == 5) ? 8'h0F : 8'(k), 32'hB000_0000 + 32'(k));
    end
    wait_idle("t2_idle", 300);
    check("t2_beats", 64'(beats - b0), 64'd16);
    check("t2_frames", 64'(frames - f0), 64'd1);
    if (rise_q.size() >= r0 + 16)
      check("t2_cadence", 64'(rise_q[r0 + 15] - rise_q[r0]), 64'(15 * (HOLD + 1)));

    // Fill to full with cmd_valid held
    b0 = beats; f0 = frames;
    vcount = 10'd100;
    acc = 0; stall = 0; budget = 0;
`ifdef PPU_CMD_VBLANK_GATE_EN
    n_offer = 17;
`else
    n_offer = 30;
`endif
    while (acc < n_offer && budget < 300 && stall < 8) begin
      cmd_valid = 1'b1;
      cmd_table = ATTR;
      cmd_index = 8'(acc);
      cmd_data  = 32'h1000_0000 + 32'(acc);
      rdy = cmd_ready;
      if (!rdy && stall == 0) check("t3_count_at_stall", 64'(fifo_count), 64'd16);
      @(posedge clk); #1;
      if (rdy) begin
        exp_q.push_back({2'b00, 2'b00, 8'(acc), 32'h1000_0000 + 32'(acc)});
        acc++;
`ifndef PPU_CMD_VBLANK_GATE_EN
        stall = 0;
`endif
      end else begin
        stall++;
      end
      budget++;
    end
`ifdef PPU_CMD_VBLANK_GATE_EN
    check("t3_accepted", 64'(acc), 64'd16);
    check("t3_full_count", 64'(fifo_count), 64'd16);
    check("t3_not_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b0;
    vcount = 10'd480;
`else
    check("t3_accepted", 64'(acc), 64'd30);
    cmd_valid = 1'b0;
`endif
    wait_idle("t3_idle", 400);
    check("t3_beats", 64'(beats - b0), 64'(acc));
    check("t3_frames", 64'(frames - f0), 64'd1);

    // Beat started on the last blanking line completes after vcount leaves it
    b0 = beats;
    vcount = 10'd523;
    push(SPRITE, 8'h44, 32'h5150_0523);
    wait_cs("t4_cs", 20);
    vcount = 10'd524;
    wait_idle("t4_idle_a", 50);
    check("t4_first_beat", 64'(beats - b0), 64'd1);
    push(SPRITE, 8'h45, 32'h5150_0524);
`ifdef PPU_CMD_VBLANK_GATE_EN
    repeat (10) @(negedge clk);
    check("t4_no_beat_524", 64'(beats - b0), 64'd1);
    check("t4_pending", 64'(fifo_count), 64'd1);
    vcount = 10'd0;
    repeat (5) @(negedge clk);
    check("t4_no_beat_0", 64'(beats - b0), 64'd1);
    vcount = 10'd480;
`endif
    wait_idle("t4_idle_b", 50);
    check("t4_second_beat", 64'(beats - b0), 64'd2);

    // Illegal table dropped at pop, error sticky
    b0 = beats; f0 = frames;
    vcount = 10'd490;
    push(2'd3, 8'd5, 32'hBAD0_0005);
    push(SPRITE, 8'd7, 32'd1);
    wait_idle("t5_idle", 50);
    check("t5_err", 64'(err_illegal), 64'd1);
    check("t5_beats", 64'(beats - b0), 64'd1);
    check("t5_frames", 64'(frames - f0), 64'd1);
    push(ATTR, 8'd1, 32'd2);
    wait_idle("t5_idle_b", 50);
    check("t5_err_sticky", 64'(err_illegal), 64'd1);
    check("t5_q_drained", 64'(exp_q.size()), 64'd0);

    // Reset during a beat drops it and the queued entry
    push(ATTR, 8'h20, 32'hDEAD_0001);
    push(ATTR, 8'h21, 32'hDEAD_0002);
    wait_cs("t6_cs", 20);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    exp_q.delete();
    b0 = beats;
    @(negedge clk);
    check("t6_cs", 64'(chipselect), 64'd0);
    check("t6_write", 64'(write), 64'd0);
    check("t6_count", 64'(fifo_count), 64'd0);
    check("t6_err_cleared", 64'(err_illegal), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    repeat (10) @(negedge clk);
    check("t6_no_more_beats", 64'(beats - b0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ppu_cmd_writer.md
Name: ppu_cmd_writer

Overview:
- Bus initiator that feeds the PPU's write-only register/memory port (chipselect, write, 12-bit address, 32-bit writedata).
- Accepts table-update commands from game logic through a ready/valid port and buffers them in a FIFO.
- Drains the FIFO as correctly-timed PPU writes, by default only during vertical blanking, so sprite, attribute and colour tables never change mid-frame.
- Sits between the game-state logic and the PPU, in the same clock domain.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of 2, at least 2.
- HOLD, 2: cycles each write beat is held on the bus; minimum 2.
- VACTIVE, 480: first blanking line.
- VTOTAL, 525: lines per frame.

Ports:
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept
- cmd_table  in  2  0 = sprite attribute, 1 = sprite pattern, 2 = colour; 3 is illegal
- cmd_index  in  8  table entry index
- cmd_data  in  32  entry payload
- vcount  in  10  current line from the VGA counters
- chipselect  out  1  PPU select
- write  out  1  PPU write strobe
- address  out  12  PPU address: [11:10] = table, [9:8] = 0, [7:0] = index
- writedata  out  32  PPU write data
- fifo_count  out  $clog2(DEPTH)+1  occupancy
- busy  out  1  FSM not in IDLE
- frame_done  out  1  1-cycle pulse when a blanking drain empties the FIFO
- err_illegal  out  1  sticky; set on an accepted cmd_table == 3

Behaviour:
- Reset (reset_n low at a clk edge):
  - FIFO emptied; state IDLE.
  - chipselect, write, frame_done, err_illegal, busy = 0.
  - address and writedata = 0; fifo_count = 0.
  - cmd_ready = 1 the cycle after reset deasserts.
  - Reset mid-beat drops the beat immediately; the entry is lost.
- Handshake:
  - A transfer occurs when cmd_valid && cmd_ready at a clk edge.
  - cmd_ready = (fifo_count < DEPTH), a combinational function of registered state.
  - Push on full cannot occur.
  - Simultaneous push and pop: count unchanged.
  - Illegal table: entry is accepted and counted, err_illegal is set, and the entry is discarded at pop with no bus cycle.
- Blank window: vblank = (vcount >= VACTIVE) && (vcount <= VTOTAL-2).
  - Line VTOTAL-1 is excluded, leaving one line of margin before active video.
- FSM states: IDLE, BEAT, GAP.
  - IDLE -> BEAT: FIFO non-empty && vblank. The head is popped, and address and writedata are registered. chipselect = write = 1 from the next cycle.
  - BEAT: the bus is held stable for exactly HOLD consecutive cycles. A hold counter loads HOLD-1 and counts down to 0. The PPU samples write combinationally one cycle after registering the address, so a single-cycle beat corrupts its address mux.
  - BEAT -> GAP: when the counter reaches 0. chipselect and write drop to 0; address and writedata hold their values.
  - GAP is one cycle, then:
    - if FIFO non-empty && vblank, go to BEAT with the next entry;
    - else go to IDLE.
  - On GAP -> IDLE with the FIFO empty and vblank true, frame_done pulses for 1 cycle.
- A beat started inside vblank always completes, even if vcount leaves the window mid-beat. No new beat starts outside the window.
- Throughput: one write per HOLD+1 cycles.
  - At defaults, 3 cycles per write; a 44-line window at 1600 cycles per line covers about 23k writes, well above DEPTH.
- Latency:
  - A push at edge t in vblank with an idle FSM gives write = 1 at t+2.
  - The pop happens at t+1: the head is visible the cycle after the push.
- fifo_count wraps correctly at pointer wrap. Pointers are $clog2(DEPTH) bits plus a wrap bit.

Optional Feature:
- Macro: PPU_CMD_VBLANK_GATE_EN.
- Defined: writes are gated to the blank window as above.
- Undefined: vblank is treated as constant 1. The FIFO drains whenever non-empty, and frame_done pulses on every transition to empty from GAP. Intended for bring-up and simulation.

Decomposition:
- Package ppu_pkg:
  - enum ppu_table_t {ATTR = 2'd0, SPRITE = 2'd1, COLOR = 2'd2}
  - localparams VACTIVE_L = 480, VTOTAL_L = 525, TABLE_LSB = 10
  - struct ppu_cmd_t {table, index, data}, 42 bits
- Sub-module cmd_fifo: synchronous FIFO of ppu_cmd_t.
  - Parameter: DEPTH.
  - Ports: push, pop, din, dout, count, full, empty; first-word-fall-through.
  - Same clk and reset_n.

Test Plan:
- Reset, then vcount = 100, push {ATTR, 3, 0xA5A5_0010} -> no write; fifo_count = 1, busy = 0. Set vcount = 480 -> chipselect = write = 1 for exactly 2 cycles with address = 0x003 and writedata = 0xA5A5_0010; then frame_done pulses; fifo_count = 0.
- vcount = 490, push 16 commands back-to-back -> cmd_ready stays 1. Writes appear every 3 cycles; an entry {COLOR, 0x0F} gives address = 0x80F; exactly 16 beats, then one frame_done.
- vcount = 100, push 17 commands with cmd_valid held -> 16 accepted, cmd_ready = 0 after the 16th, fifo_count = 16.
- Beat starts at vcount = 523 and vcount steps to 524 mid-beat -> the beat completes its 2 cycles; no further beat until vcount = 480 of the next frame.
- Push {table 3} then {SPRITE, 7, 1} during vblank -> err_illegal = 1 and sticky; only one bus beat occurs, with address = 0x407.
- Assert reset_n = 0 during a BEAT cycle -> the next cycle has chipselect = write = 0 and fifo_count = 0; no further writes.
